// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Time-multiplexes a 16-bit hex word onto a 4-digit, common-anode,
//   active-low 7-segment display. A free-running prescaler produces one
//   tick per digit slot, and each tick advances a 2-bit digit index.
//   At the end of every frame the displayed value and decimal-point mask are
//   copied into shadow registers. The display therefore never shows a mix
//   of old and new digits.
//
// Parameters:
//   PRESCALE  clk cycles per digit slot (must be >= 2)
//   BLANK_LZ  1 = blank leading-zero digits (digit 0 is never blanked)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-low reset (0 = reset)
//   value       in   16-bit hex value; value[3:0] is digit 0 (rightmost)
//   dp_mask     in   decimal-point enable per digit, 1 = point on
//   blank       in   1 = all anodes off; scanning keeps running
//   seg         out  {g,f,e,d,c,b,a}, active-low, registered
//   dp          out  decimal point, active-low, registered
//   an          out  digit anodes, active-low, an[0] = digit 0, registered
//   frame_done  out  high for the single cycle whose edge reloads the shadow
//
// Handshake:
//   There is no handshake. value and dp_mask are sampled only on the reload
//   edge. That edge is the clock edge that ends the cycle in which
//   frame_done is high.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int PRESCALE = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int            CW      = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    dp_shadow_q, dp_shadow_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          tick;
    logic          reload;
    logic [15:0]   shifted;
    logic [3:0]    nibble;
    logic          lz_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick   = (cnt_q == CNT_MAX);
    assign reload = tick && (idx_q == 2'd3);

    // Shifting the shadow right by 4*idx puts the current digit in the low
    // nibble. Whatever remains above it holds the more-significant digits.
    // If the whole shifted word is zero, this digit is a leading zero.
    assign shifted  = shadow_q >> {idx_q, 2'b00};
    assign nibble   = shifted[3:0];
    assign lz_blank = BLANK_LZ && (idx_q != 2'd0) && (shifted == 16'h0000);

    always_comb begin
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        dp_shadow_d = dp_shadow_q;

        if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        // The reload shares its edge with the idx 3->0 wrap. Digit 0 of the
        // new frame therefore already decodes the new shadow.
        if (reload) begin
            shadow_d    = value;
            dp_shadow_d = dp_mask;
        end

        seg_d = lz_blank ? 7'b1111111 : hex_to_seg(nibble);
        dp_d  = ~dp_shadow_q[idx_q];
        an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            shadow_q    <= 16'h0000;
            dp_shadow_q <= 4'h0;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
            an_q        <= 4'b1111;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            dp_shadow_q <= dp_shadow_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = reload;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Runs two instances of seg7_scan_driver with PRESCALE=4. Both instances share
// the same inputs. One instance has leading-zero blanking on, the other off.
//
// The reference model counts clock edges since reset release. From that count
// it works out, with plain arithmetic:
//   - the digit slot,
//   - the frame boundaries,
//   - the frame_done cycle.
// It keeps the last value latched at a frame boundary. Every cycle it pushes
// the expected outputs of both instances into exp_q. A separate monitor pops
// one entry per cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int P     = 4;
    localparam int FRAME = 4 * P;
    localparam int W     = 26;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        blank;

    logic [6:0]  seg,    nb_seg;
    logic        dp,     nb_dp;
    logic [3:0]  an,     nb_an;
    logic        frame_done, nb_fd;

    int          tests  = 0;
    int          errors = 0;
    int          e      = 0;   // clock edges since reset release
    logic [W-1:0] exp_q[$];

    logic [6:0] seg_lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_driver #(.PRESCALE(P), .BLANK_LZ(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank      (blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    seg7_scan_driver #(.PRESCALE(P), .BLANK_LZ(1'b0)) dut_nb (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank      (blank),
        .seg        (nb_seg),
        .dp         (nb_dp),
        .an         (nb_an),
        .frame_done (nb_fd)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_shadow = 16'h0000;
    logic [3:0]  m_dp     = 4'h0;

    initial begin
        int         digit;
        logic [3:0] nib;
        logic       lz;
        logic [6:0] s_exp, s_nb;
        logic       d_exp, fd_exp;
        logic [3:0] a_exp;
        forever begin
            @(posedge clk);
            if (!rst) begin
                e        = 0;
                m_shadow = 16'h0000;
                m_dp     = 4'h0;
                exp_q.push_back({1'b0, 4'hF, 1'b1, 7'h7F, 1'b0, 4'hF, 1'b1, 7'h7F});
            end else begin
                e      = e + 1;
                // Outputs after edge e show the slot that was active before that edge.
                digit  = ((e - 1) / P) % 4;
                nib    = 4'((m_shadow >> (4 * digit)) % 16);
                lz     = (digit > 0) && ((m_shadow >> (4 * digit)) == 0);
                s_nb   = seg_lut[nib];
                s_exp  = lz ? 7'h7F : s_nb;
                d_exp  = ~m_dp[digit];
                a_exp  = blank ? 4'hF : ~(4'(1 << digit));
                fd_exp = ((e + 1) % FRAME) == 0;
                exp_q.push_back({fd_exp, a_exp, d_exp, s_exp, fd_exp, a_exp, d_exp, s_nb});
                // Every FRAME edges the display latches the current inputs.
                if ((e % FRAME) == 0) begin
                    m_shadow = value;
                    m_dp     = dp_mask;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] got, ex;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ex  = exp_q.pop_front();
                got = {frame_done, an, dp, seg, nb_fd, nb_an, nb_dp, nb_seg};
                tests++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL scan_outputs t=%0t e=%0d got fd=%b an=%b dp=%b seg=%b | nb fd=%b an=%b dp=%b seg=%b ; required fd=%b an=%b dp=%b seg=%b | nb fd=%b an=%b dp=%b seg=%b",
                             $time, e,
                             got[25], got[24:21], got[20], got[19:13],
                             got[12], got[11:8], got[7], got[6:0],
                             ex[25], ex[24:21], ex[20], ex[19:13],
                             ex[12], ex[11:8], ex[7], ex[6:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] rand_value();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 15));
            2:       return 16'($urandom_range(0, 255));
            default: return 16'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) value   = rand_value();
            if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic reset_mid_slot();
        int waited;
        waited = 0;
        // Wait for the middle of the idx=2 slot, with a cycle budget.
        while (!(((e / P) % 4) == 2 && (e % P) == 1) && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (waited >= 64) begin
            errors++;
            $display("FAIL reset_wait_idx2 got timeout after %0d cycles required idx=2 slot", waited);
        end
        #1 rst = 1'b0;
        #1;
        tests++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        run_cycles(2);
        #1 rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b0;
        value   = 16'h12AF;
        dp_mask = 4'b0100;
        blank   = 1'b0;

        run_cycles(3);
        #1;
        tests++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle got an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        rst = 1'b1;

        // First frame shows 0, next two show 12AF.
        run_cycles(2 * FRAME + 6);
        // Mid-frame change: must not appear before the next reload.
        value = 16'h3456;
        run_cycles(2 * FRAME);
        value   = 16'h0005;
        dp_mask = 4'b0000;
        run_cycles(2 * FRAME);
        value = 16'h0000;
        run_cycles(2 * FRAME);
        value   = 16'hF00D;
        dp_mask = 4'b1001;
        blank   = 1'b1;
        run_cycles(6);
        blank = 1'b0;
        run_cycles(FRAME);

        run_random(600);
        blank = 1'b0;
        reset_mid_slot();
        run_random(400);

        run_cycles(3);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
